// File: rtl/fft_frame_buffer.sv
`timescale 1ns/1ps
// fft_frame_buffer: ping-pong capture of ADC samples into frames, streamed to an FFT over valid/ready.
// Define OFFSET_BIN_EN to flip the sample MSB on capture (offset-binary -> two's complement).
module fft_frame_buffer #(
   parameter int DATA_W    = 20,
   parameter int FRAME_LEN = 32
) (
   input  logic              clk_lvds,
   input  logic              arstb,
   input  logic              freeze,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] fft_data,
   output logic              fft_valid,
   output logic              fft_last,
   input  logic              fft_ready,
   output logic              ovf
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] adc_q, wdata;
   logic              adc_vld_q;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ovf_q, ovf_d;
   logic [1:0]        full_q, full_d;
   logic              wr_wrap, rd_hs, rd_done, other_busy, commit;
   logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

`ifdef OFFSET_BIN_EN
   assign wdata = {~adc_q[DATA_W-1], adc_q[DATA_W-2:0]};
`else
   assign wdata = adc_q;
`endif

   assign wr_wrap    = adc_vld_q && (wr_ptr_q == LAST);
   assign rd_hs      = (state_q == STREAM) && fft_ready;
   assign rd_done    = rd_hs && (rd_ptr_q == LAST);
   // a bank released by the reader on this same edge counts as free
   assign other_busy = full_q[~wr_bank_q] && !(rd_done && (rd_bank_q != wr_bank_q));
   assign commit     = wr_wrap && !other_busy;
   assign ovf        = ovf_q;

   always_comb begin
      wr_ptr_d  = wr_wrap ? '0 : (adc_vld_q ? wr_ptr_q + AW'(1) : wr_ptr_q);
      wr_bank_d = commit ? ~wr_bank_q : wr_bank_q;
      rd_ptr_d  = rd_done ? '0 : (rd_hs ? rd_ptr_q + AW'(1) : rd_ptr_q);
      rd_bank_d = rd_done ? ~rd_bank_q : rd_bank_q;
      ovf_d     = ovf_q | (wr_wrap && other_busy);
      full_d    = full_q;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
      if (commit) full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clk_lvds or negedge arstb) begin
      if (!arstb) begin
         adc_q     <= '0;
         adc_vld_q <= 1'b0;
         wr_ptr_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_ptr_q  <= '0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         adc_q     <= adc_data;
         adc_vld_q <= ~freeze;
         wr_ptr_q  <= wr_ptr_d;
         wr_bank_q <= wr_bank_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge clk_lvds) begin
      if (adc_vld_q) mem_q[wr_bank_q][wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk_lvds or negedge arstb) begin
      if (!arstb) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (full_q[rd_bank_q]) state_d = STREAM;
         STREAM:  if (rd_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fft_valid = (state_q == STREAM);
      fft_last  = fft_valid && (rd_ptr_q == LAST);
      fft_data  = fft_valid ? mem_q[rd_bank_q][rd_ptr_q] : '0;
   end
endmodule

// File: tb/tb_fft_frame_buffer.sv
`timescale 1ns/1ps
// tb_fft_frame_buffer: directed checks of capture, streaming, freeze, overflow, reset and offset-binary option.
module tb_fft_frame_buffer;
   localparam int DW = 20;
   localparam int FL = 32;

   logic          clk_lvds = 1'b0;
   logic          arstb = 1'b1;
   logic          freeze = 1'b1;
   logic          fft_ready = 1'b0;
   logic [DW-1:0] adc_data = '0;
   logic [DW-1:0] fft_data;
   logic          fft_valid, fft_last, ovf;

   int            errors = 0;
   int            checks = 0;
   int            nxt = 0;
   int            hold_err = 0;
   logic          tgl = 1'b0;
   logic [DW:0]   q[$];
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;
   logic          hold_l = 1'b0;

   always #5 clk_lvds = ~clk_lvds;

   fft_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
      .clk_lvds (clk_lvds),
      .arstb    (arstb),
      .freeze   (freeze),
      .adc_data (adc_data),
      .fft_data (fft_data),
      .fft_valid(fft_valid),
      .fft_last (fft_last),
      .fft_ready(fft_ready),
      .ovf      (ovf)
   );

   // record every accepted sample and verify data/last hold while stalled
   initial forever begin
      @(negedge clk_lvds);
      if (fft_valid && fft_ready) q.push_back({fft_last, fft_data});
      if (hold_v && fft_valid && (fft_data !== hold_d || fft_last !== hold_l)) hold_err++;
      hold_v = fft_valid && !fft_ready;
      hold_d = fft_data;
      hold_l = fft_last;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_lvds);
      #1;
   endtask

   task automatic put_v(input logic [DW-1:0] v, input logic frz);
      adc_data = v;
      freeze = frz;
      if (tgl) fft_ready = ~fft_ready;
      tick();
   endtask

   task automatic put(input logic frz);
      put_v(DW'(nxt), frz);
      if (!frz) nxt++;
   endtask

   task automatic do_reset();
      arstb = 1'b0;
      freeze = 1'b1;
      fft_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(fft_valid), 0);
      chk("rst_last", 32'(fft_last), 0);
      chk("rst_data", 32'(fft_data), 0);
      chk("rst_ovf", 32'(ovf), 0);
      #1 arstb = 1'b1;
      q.delete();
      nxt = 0;
   endtask

   task automatic run_until(input int n, input int budget, input logic frz, input string tag);
      int b = 0;
      while (q.size() < n && b < budget) begin
         put(frz);
         b++;
      end
      chk(tag, q.size(), n);
   endtask

   function automatic int frame_bad(input int off, input int base);
      int n = 0;
      logic [DW:0] e;
      for (int i = 0; i < FL; i++) begin
         e = {(i == FL - 1), DW'(base + i)};
         if (off + i >= q.size()) n++;
         else if (q[off + i] !== e) n++;
      end
      return n;
   endfunction

   function automatic logic [31:0] qget(input int k);
      return (k < q.size()) ? 32'(q[k][DW-1:0]) : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic [31:0] e0, e1, e2;
      tick();
      do_reset();

      // ramp with ready high; one freeze cycle makes frame 1 wrap on the release edge
      fft_ready = 1'b1;
      repeat (33) put(1'b0);
      chk("t1_valid_early", 32'(fft_valid), 0);
      put(1'b0);
      chk("t1_valid_rise", 32'(fft_valid), 1);
      chk("t1_first_data", 32'(fft_data), 0);
      chk("t1_ovf_clear", 32'(ovf), 0);
      repeat (6) put(1'b0);
      put(1'b1);
      run_until(33, 200, 1'b0, "t1_count33");
      chk("t1_release_no_drop", 32'(ovf), 0);
      run_until(64, 200, 1'b0, "t1_count64");
      chk("t1_frame0", frame_bad(0, 0), 0);
      chk("t1_frame1", frame_bad(32, 32), 0);

      // ready toggling, then reset mid-stream
      do_reset();
      tgl = 1'b1;
      run_until(20, 200, 1'b0, "t2_pre_count");
      chk("t2_pre_valid", 32'(fft_valid), 1);
      chk("t2_pre_ovf", 32'(ovf), 1);
      do_reset();
      nxt = 1000;
      run_until(32, 300, 1'b0, "t2_count");
      chk("t2_frame", frame_bad(0, 1000), 0);
      chk("t2_hold", hold_err, 0);
      tgl = 1'b0;

      // freeze for 5 cycles after sample 10
      do_reset();
      fft_ready = 1'b1;
      repeat (11) put(1'b0);
      repeat (5) put(1'b1);
      repeat (22) put(1'b0);
      chk("t3_valid_early", 32'(fft_valid), 0);
      put(1'b0);
      chk("t3_valid_rise", 32'(fft_valid), 1);
      run_until(32, 100, 1'b0, "t3_count");
      chk("t3_frame", frame_bad(0, 0), 0);

      // reader stalled: frames 32..63 and 64..95 dropped
      do_reset();
      repeat (96) put(1'b0);
      put(1'b1);
      chk("t4_ovf", 32'(ovf), 1);
      chk("t4_stall_valid", 32'(fft_valid), 1);
      chk("t4_stall_data", 32'(fft_data), 0);
      chk("t4_no_accept", q.size(), 0);
      fft_ready = 1'b1;
      run_until(32, 100, 1'b1, "t4_count32");
      chk("t4_frame0", frame_bad(0, 0), 0);
      run_until(64, 200, 1'b0, "t4_count64");
      chk("t4_frame3", frame_bad(32, 96), 0);
      chk("t4_ovf_sticky", 32'(ovf), 1);

      // sample MSB handling
`ifdef OFFSET_BIN_EN
      e0 = 32'h00000; e1 = 32'h80001; e2 = 32'hFFFFF;
`else
      e0 = 32'h80000; e1 = 32'h00001; e2 = 32'h7FFFF;
`endif
      do_reset();
      fft_ready = 1'b1;
      put_v(20'h80000, 1'b0);
      put_v(20'h00001, 1'b0);
      put_v(20'h7FFFF, 1'b0);
      repeat (29) put(1'b0);
      run_until(3, 50, 1'b0, "t5_count");
      chk("t5_msb_set", qget(0), e0);
      chk("t5_msb_clear", qget(1), e1);
      chk("t5_max_pos", qget(2), e2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
